fdiv_seq: RTL and testbench

Parametrised, multi-cycle IEEE-754 floating-point divider producing one quotient bit per clock by restoring division. It is the next generation of the lab-2 single-precision divider: exponent and mantissa widths are generic, and it adds a start/done handshake, special-operand handling, exponent range checks and selectable rounding. It sits beside the adder and multiplier in the FP datapath and is driven by the same controller.

---
 rtl/fdiv_seq.sv | 188 ++++++++++++++++++
 tb/tb_fdiv_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fdiv_seq.sv
// Multi-cycle IEEE-754 divider, one quotient bit per clock (restoring), FTZ, start/done handshake.
// Define FDIV_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fdiv_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] res,
  output logic [3:0]           flags
);

  localparam int DATA_W = 1 + EXP_W + MAN_W;
  localparam int Q_W    = MAN_W + 3;
  localparam int R_W    = MAN_W + 2;
  localparam int E_W    = EXP_W + 2;
  localparam int CNT_W  = $clog2(Q_W);
  localparam logic signed [E_W-1:0] BIAS   = E_W'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [E_W-1:0] E_MAX  = E_W'((1 << EXP_W) - 1);
  localparam logic signed [E_W-1:0] E_ZERO = '0;
  localparam logic signed [E_W-1:0] E_ONE  = E_W'(1);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(Q_W - 1);
`ifdef FDIV_RNE_EN
  localparam bit RNE_EN = 1'b1;
`else
  localparam bit RNE_EN = 1'b0;
`endif

  typedef enum logic [2:0] {IDLE, PREP, ITER, NORM, ROUND, DONE} state_t;

  state_t                  state;
  logic [CNT_W-1:0]        cnt;
  logic [DATA_W-1:0]       a_r, b_r;
  logic [R_W-1:0]          rem, dvs, rem_nxt;
  logic [Q_W-1:0]          quo;
  logic signed [E_W-1:0]   e_r, e_rnd;
  logic                    sticky_r, ge;
  logic                    spec_r;
  logic [DATA_W-1:0]       spec_res_r;
  logic [3:0]              spec_flg_r;

  function automatic logic [MAN_W:0] round_frac(input logic [MAN_W-1:0] frac,
                                                input logic guard, input logic sticky);
    return {1'b0, frac} + (MAN_W+1)'(RNE_EN & guard & (sticky | frac[0]));
  endfunction

  logic [EXP_W-1:0]  ea, eb;
  logic [MAN_W-1:0]  ma, mb;
  logic              sgn, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [DATA_W-1:0] inf_val, zero_val, qnan_val;

  assign ea       = a_r[DATA_W-2 -: EXP_W];
  assign eb       = b_r[DATA_W-2 -: EXP_W];
  assign ma       = a_r[MAN_W-1:0];
  assign mb       = b_r[MAN_W-1:0];
  assign sgn      = a_r[DATA_W-1] ^ b_r[DATA_W-1];
  assign a_zero   = (ea == '0);
  assign b_zero   = (eb == '0);
  assign a_inf    = (&ea) && (ma == '0);
  assign b_inf    = (&eb) && (mb == '0);
  assign a_nan    = (&ea) && (ma != '0);
  assign b_nan    = (&eb) && (mb != '0);
  assign inf_val  = {sgn, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  assign zero_val = {sgn, {(DATA_W-1){1'b0}}};
  assign qnan_val = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  logic              spec_hit;
  logic [DATA_W-1:0] spec_val;
  logic [3:0]        spec_flg;

  always_comb begin
    spec_hit = 1'b1;
    spec_val = zero_val;
    spec_flg = 4'b0000;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_val = qnan_val;
      spec_flg = 4'b1000;
    end else if (a_inf) begin
      spec_val = inf_val;
    end else if (b_inf || a_zero) begin
      spec_val = zero_val;
    end else if (b_zero) begin
      spec_val = inf_val;
      spec_flg = 4'b0100;
    end else begin
      spec_hit = 1'b0;
    end
  end

  assign ge      = (rem >= dvs);
  assign rem_nxt = ge ? (rem - dvs) : rem;

  // Round stage: quo is normalised here, so quo[Q_W-1] is the hidden bit.
  logic [MAN_W:0]    mant_rnd;
  logic [DATA_W-1:0] rnd_val;
  logic [3:0]        rnd_flg;

  always_comb begin
    mant_rnd = round_frac(quo[Q_W-2:2], quo[1], sticky_r | quo[0]);
    e_rnd    = e_r + $signed({{(E_W-1){1'b0}}, mant_rnd[MAN_W]});
    rnd_val  = {sgn, e_rnd[EXP_W-1:0], mant_rnd[MAN_W-1:0]};
    rnd_flg  = 4'b0000;
    if (e_rnd >= E_MAX) begin
      rnd_val = inf_val;
      rnd_flg = 4'b0010;
    end else if (e_rnd <= E_ZERO) begin
      rnd_val = zero_val;
      rnd_flg = 4'b0001;
    end
  end

  // Datapath registers carry no reset; every field is loaded before it is read.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (start) begin
        a_r <= a;
        b_r <= b;
      end
      PREP: begin
        spec_r     <= spec_hit;
        spec_res_r <= spec_val;
        spec_flg_r <= spec_flg;
        e_r        <= $signed({2'b00, ea}) - $signed({2'b00, eb}) + BIAS;
        rem        <= {1'b0, 1'b1, ma};
        dvs        <= {1'b0, 1'b1, mb};
        quo        <= '0;
      end
      ITER: begin
        quo <= {quo[Q_W-2:0], ge};
        rem <= rem_nxt << 1;
      end
      NORM: begin
        if (!quo[Q_W-1]) begin
          quo <= quo << 1;
          e_r <= e_r - E_ONE;
        end
        sticky_r <= |rem;
      end
      default: ;
    endcase
  end

  // Specials pass through ROUND so every result is published on the edge into DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      res   <= '0;
      flags <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= PREP;
          busy  <= 1'b1;
        end
        PREP: begin
          cnt   <= '0;
          state <= spec_hit ? ROUND : ITER;
        end
        ITER: begin
          if (cnt == CNT_LAST) state <= NORM;
          else                 cnt   <= cnt + 1'b1;
        end
        NORM: state <= ROUND;
        ROUND: begin
          res   <= spec_r ? spec_res_r : rnd_val;
          flags <= spec_r ? spec_flg_r : rnd_flg;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_seq.sv
// Bench for fdiv_seq: single- and half-precision instances, vector table plus handshake/reset sequences.
module tb_fdiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_s, start_h;
  logic [31:0] a_s, b_s, res_s;
  logic [15:0] a_h, b_h, res_h;
  logic        busy_s, busy_h, done_s, done_h;
  logic [3:0]  flags_s, flags_h;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fdiv_seq dut_s (
    .clk(clk), .rst_n(rst_n), .start(start_s), .a(a_s), .b(b_s),
    .busy(busy_s), .done(done_s), .res(res_s), .flags(flags_s)
  );

  fdiv_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst_n(rst_n), .start(start_h), .a(a_h), .b(b_h),
    .busy(busy_h), .done(done_h), .res(res_h), .flags(flags_h)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic [3:0]  f;
    int          lat;
    bit          half;
  } vec_t;

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          id;
  } exp_t;

  vec_t vt[$];
  exp_t q_s[$];
  exp_t q_h[$];

`ifdef FDIV_RNE_EN
  localparam logic [31:0] THIRD = 32'h3EAAAAAB;
`else
  localparam logic [31:0] THIRD = 32'h3EAAAAAA;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic add_vec(input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vr,
                         input logic [3:0] vf, input int lat, input bit half);
    vec_t v;
    v.a = va; v.b = vb; v.r = vr; v.f = vf; v.lat = lat; v.half = half;
    vt.push_back(v);
  endtask

  // Scoreboard: every done pops one expected record for that instance.
  always @(negedge clk) begin
    exp_t e;
    if (done_s) begin
      if (q_s.size() == 0) check("spurious done sp", {31'b0, done_s}, 32'd0);
      else begin
        e = q_s.pop_front();
        check($sformatf("v%0d res", e.id), res_s, e.r);
        check($sformatf("v%0d flags", e.id), {28'b0, flags_s}, {28'b0, e.f});
      end
    end
    if (done_h) begin
      if (q_h.size() == 0) check("spurious done hp", {31'b0, done_h}, 32'd0);
      else begin
        e = q_h.pop_front();
        check($sformatf("v%0d res", e.id), {16'b0, res_h}, e.r);
        check($sformatf("v%0d flags", e.id), {28'b0, flags_h}, {28'b0, e.f});
      end
    end
  end

  task automatic run_op(input int id, input bit half, input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] vr, input logic [3:0] vf, input int lat,
                        input int ign1, input int ign2);
    exp_t e;
    int   n;
    bit   seen;
    @(negedge clk);
    e.r = vr; e.f = vf; e.id = id;
    if (half) begin
      a_h = va[15:0]; b_h = vb[15:0]; start_h = 1'b1; q_h.push_back(e);
    end else begin
      a_s = va; b_s = vb; start_s = 1'b1; q_s.push_back(e);
    end
    @(posedge clk); #1;
    start_s = 1'b0; start_h = 1'b0;
    a_s = $urandom; b_s = $urandom; a_h = 16'($urandom); b_h = 16'($urandom);
    check($sformatf("v%0d busy after accept", id), {31'b0, half ? busy_h : busy_s}, 32'd1);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge clk); #1;
      n++;
      start_s = 1'b0;
      if (n == ign1 || n == ign2) begin
        start_s = 1'b1; a_s = 32'hBF800000; b_s = 32'h0;
      end
      if (half ? done_h : done_s) seen = 1'b1;
    end
    check($sformatf("v%0d done cycle", id), n, lat);
    @(posedge clk); #1;
    check($sformatf("v%0d busy after done", id), {31'b0, half ? busy_h : busy_s}, 32'd0);
    check($sformatf("v%0d done pulse width", id), {31'b0, half ? done_h : done_s}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int ndone;
    rst_n = 1'b0; start_s = 1'b0; start_h = 1'b0;
    a_s = '0; b_s = '0; a_h = '0; b_h = '0;

    add_vec(32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29, 1'b0);
    add_vec(32'h3F800000, 32'h40400000, THIRD,        4'b0000, 29, 1'b0);
    add_vec(32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100,  2, 1'b0);
    add_vec(32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000,  2, 1'b0);
    add_vec(32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 29, 1'b0);
    add_vec(32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 29, 1'b0);
    add_vec(32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000,  2, 1'b0);
    add_vec(32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000,  2, 1'b0);
    add_vec(32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000,  2, 1'b0);
    add_vec(32'h3F800000, 32'hFF800000, 32'h80000000, 4'b0000,  2, 1'b0);
    add_vec(32'h80000000, 32'h40400000, 32'h80000000, 4'b0000,  2, 1'b0);
    add_vec(32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000, 29, 1'b0);
    add_vec(32'h3F800000, 32'h3F800001, 32'h3F7FFFFE, 4'b0000, 29, 1'b0);
    add_vec(32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000,  2, 1'b0);
    add_vec(32'h40000000, 32'h007FFFFF, 32'h7F800000, 4'b0100,  2, 1'b0);
    add_vec(32'h00004600, 32'h00004000, 32'h00004200, 4'b0000, 16, 1'b1);
    add_vec(32'h00003C00, 32'h00004200, 32'h00003555, 4'b0000, 16, 1'b1);
    add_vec(32'h00003C00, 32'h00000000, 32'h00007C00, 4'b0100,  2, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'b0, busy_s}, 32'd0);
    check("reset done", {31'b0, done_s}, 32'd0);
    check("reset res", res_s, 32'd0);
    check("reset flags", {28'b0, flags_s}, 32'd0);
    check("reset res hp", {16'b0, res_h}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vt.size(); i++)
      run_op(i, vt[i].half, vt[i].a, vt[i].b, vt[i].r, vt[i].f, vt[i].lat, 0, 0);

    // start pulses while busy must not disturb the running operation
    run_op(100, 1'b0, 32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 29, 5, 10);
    repeat (5) @(posedge clk);
    #1;
    check("result held", res_s, 32'h40400000);
    check("idle after ignored starts", {31'b0, busy_s}, 32'd0);

    // reset in the middle of an operation
    @(negedge clk);
    a_s = 32'h40C00000; b_s = 32'h3F800000; start_s = 1'b1;
    @(posedge clk); #1;
    start_s = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midop reset busy", {31'b0, busy_s}, 32'd0);
    check("midop reset done", {31'b0, done_s}, 32'd0);
    check("midop reset res", res_s, 32'd0);
    check("midop reset flags", {28'b0, flags_s}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done_s) ndone++;
    end
    check("no done after reset", ndone, 0);
    run_op(101, 1'b0, 32'h3F800000, 32'h40400000, THIRD, 4'b0000, 29, 0, 0);

    repeat (3) @(posedge clk);
    check("pending sp results", q_s.size(), 0);
    check("pending hp results", q_h.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
